lp_pivot_sequencer: RTL
=======================

# lp_pivot_sequencer

Top-level simplex iteration controller for the LP datapath. It sequences the three per-iteration stages: pivot-column selection, pivot-row ratio test and tableau row update. Each stage's floating-point IP gets a clean two-cycle reset, and its column streamer gets a start pulse. The block latches each stage's result, counts iterations and reports a final status (optimal, unbounded, iteration limit, or timeout) to the host.

## Interface
Parameters:
- DATAW, 32, tableau element width (IEEE-754 single)
- NUM_ROWS_W, 16, row index width
- NUM_COLS_W, 16, column index width
- MAX_ITER_W, 16, iteration counter width
- WDOG_CYCLES, 65535, per-stage run timeout (used only with watchdog compiled in)

Ports:
- clk  in  1  clock
- resetn  in  1  reset resetn, synchronous, active-low; clock clk
- start  in  1  begin solve (sampled in IDLE or DONE)
- max_iter  in  MAX_ITER_W  iteration limit, sampled on accepted start; 0 treated as 1
- col_resetn  out  1  reset to pivot-column stage
- col_stream_start  out  1  one-cycle pulse, objective-row streamer
- col_cont, col_terminate  in  1 each  pivot-column stage result flags
- col_index_in  in  NUM_COLS_W  chosen pivot column
- row_resetn  out  1  reset to pivot-row stage
- row_stream_start  out  1  one-cycle pulse, right-column and pivot-column streamers
- row_cont, row_terminate  in  1 each  pivot-row stage result flags
- row_index_in  in  NUM_ROWS_W  chosen pivot row
- pivot_elem_in  in  DATAW  pivot element
- upd_start  out  1  one-cycle pulse to row-update engine
- upd_done  in  1  row update complete (level or pulse)
- pivot_col  out  NUM_COLS_W  latched pivot column
- pivot_row  out  NUM_ROWS_W  latched pivot row
- pivot_elem  out  DATAW  latched pivot element
- iter_count  out  MAX_ITER_W  completed iterations
- busy  out  1  high outside IDLE and DONE
- done  out  1  high in DONE
- status  out  3  0 none, 1 optimal, 2 unbounded, 3 iteration limit, 4 timeout

## Operation
- States: IDLE, COL_RST, COL_RUN, ROW_RST, ROW_RUN, UPD, DONE. This is a Moore FSM; all outputs are registered.
- IDLE: col_resetn and row_resetn are 0. On start: clear iter_count, clear status, latch max_iter, go to COL_RST.
- COL_RST: col_resetn=0 for exactly 2 cycles, then COL_RUN.
- COL_RUN: col_resetn=1. col_stream_start=1 only in the first cycle.
  - col_terminate → DONE, status=1.
  - Else col_cont → latch pivot_col ← col_index_in, go to ROW_RST.
  - Both flags high in the same cycle: terminate wins.
- ROW_RST: row_resetn=0 for exactly 2 cycles, then ROW_RUN.
- ROW_RUN: row_resetn=1. row_stream_start is pulsed in the first cycle only.
  - row_terminate → DONE, status=2.
  - Else row_cont → latch pivot_row and pivot_elem, go to UPD.
  - Both flags high in the same cycle: terminate wins.
- UPD: upd_start is pulsed in the first cycle only. On upd_done: iter_count+1.
  - If the new count ≥ max_iter → DONE, status=3.
  - Else → COL_RST.
  - upd_done in the same cycle as the upd_start pulse is accepted.
- Reset values when not in their own RST state:
  - col_resetn is 1 outside IDLE and COL_RST.
  - row_resetn is 1 outside IDLE and ROW_RST.
  - In DONE, both are held at 1 so stage results remain observable.
- DONE: done=1, status and latched outputs are held. start → COL_RST with iter_count and status cleared.
- Stage flags arriving outside their RUN state are ignored.
- iter_count saturates at all-ones and never wraps.

## Timing
- Reset (resetn=0 at a clk edge): next state IDLE. All outputs reset to:
  - col_resetn=0, row_resetn=0
  - all pulses 0
  - pivot_col, pivot_row, pivot_elem, iter_count = 0
  - busy=0, done=0, status=0
- Reset mid-operation aborts immediately; no pulse is emitted afterwards.
- start accepted at edge N → COL_RST in cycles N+1..N+2 → col_stream_start high in cycle N+3.
- Flag sampled at edge M → next stage reset is low in cycles M+1..M+2.
- Each stage reset is low for exactly 2 cycles, which meets the floating-point IP's minimum reset length.
- Minimum iteration overhead (flags immediate): 2+1+2+1+1 = 7 cycles.
- done rises the cycle after the terminating flag or final upd_done is sampled.

## Configuration
- LP_SEQ_WATCHDOG_EN defined: a cycle counter clears on entry to COL_RUN, ROW_RUN or UPD and increments each cycle there. When it reaches WDOG_CYCLES without an exit flag → DONE, status=4.
- Not defined: no counter, status never 4, and the FSM waits indefinitely in RUN/UPD states.

## Test plan
- start, max_iter=5, col_terminate 10 cycles after col_stream_start → done, status=1, iter_count=0, col_resetn low exactly 2 cycles.
- Col cont (index 3), then row cont (row 7, pivot_elem 0x40000000), upd_done; second pass col_terminate → status=1, iter_count=1, pivot_col=3, pivot_row=7, pivot_elem=0x40000000.
- Col cont, then row_terminate → status=2, no upd_start pulse seen.
- max_iter=2, every stage continues → exactly two upd_start pulses, status=3, iter_count=2.
- col_cont and col_terminate asserted simultaneously → status=1. resetn low for 1 cycle mid ROW_RUN → all outputs return to reset values, state IDLE.
- With LP_SEQ_WATCHDOG_EN and WDOG_CYCLES=16, no row flag ever → done after 16 cycles in ROW_RUN, status=4.

Source files
------------

// File: rtl/lp_pivot_sequencer_if.sv
// Stage-side bus of the simplex pivot sequencer. It carries the resets and
// start pulses sent to the column, row and update stages, and the result
// flags and data that come back from them.
// master: the sequencer. slave: the LP datapath stages.
interface lp_pivot_sequencer_if #(
  parameter int DATAW      = 32,
  parameter int NUM_ROWS_W = 16,
  parameter int NUM_COLS_W = 16
);
  logic                  col_resetn;
  logic                  col_stream_start;
  logic                  col_cont;
  logic                  col_terminate;
  logic [NUM_COLS_W-1:0] col_index_in;
  logic                  row_resetn;
  logic                  row_stream_start;
  logic                  row_cont;
  logic                  row_terminate;
  logic [NUM_ROWS_W-1:0] row_index_in;
  logic [DATAW-1:0]      pivot_elem_in;
  logic                  upd_start;
  logic                  upd_done;

  modport master (
    output col_resetn, col_stream_start, row_resetn, row_stream_start, upd_start,
    input  col_cont, col_terminate, col_index_in,
    input  row_cont, row_terminate, row_index_in, pivot_elem_in,
    input  upd_done
  );

  modport slave (
    input  col_resetn, col_stream_start, row_resetn, row_stream_start, upd_start,
    output col_cont, col_terminate, col_index_in,
    output row_cont, row_terminate, row_index_in, pivot_elem_in,
    output upd_done
  );
endinterface

// File: rtl/lp_pivot_sequencer.sv
// Simplex iteration controller. It runs pivot-column selection, the pivot-row
// ratio test and the tableau row update in sequence. Each floating-point
// stage gets a two-cycle reset followed by a one-cycle streamer start. The
// controller latches the stage results, counts iterations and reports the
// final status.
// Optional feature: define LP_SEQ_WATCHDOG_EN to add a per-stage run timeout
// of WDOG_CYCLES cycles, which ends the solve with status 4.
// Moore FSM: every output comes from a register loaded with the decode of the
// next state.
module lp_pivot_sequencer #(
  parameter int          DATAW       = 32,
  parameter int          NUM_ROWS_W  = 16,
  parameter int          NUM_COLS_W  = 16,
  parameter int          MAX_ITER_W  = 16,
  parameter int unsigned WDOG_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [MAX_ITER_W-1:0]   max_iter,
  lp_pivot_sequencer_if.master    stg,
  output logic [NUM_COLS_W-1:0]   pivot_col,
  output logic [NUM_ROWS_W-1:0]   pivot_row,
  output logic [DATAW-1:0]        pivot_elem,
  output logic [MAX_ITER_W-1:0]   iter_count,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              status
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COL_RST = 3'd1,
    S_COL_RUN = 3'd2,
    S_ROW_RST = 3'd3,
    S_ROW_RUN = 3'd4,
    S_UPD     = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [2:0] STATUS_NONE      = 3'd0;
  localparam logic [2:0] STATUS_OPTIMAL   = 3'd1;
  localparam logic [2:0] STATUS_UNBOUNDED = 3'd2;
  localparam logic [2:0] STATUS_ITER_LIM  = 3'd3;
  localparam logic [2:0] STATUS_TIMEOUT   = 3'd4;

  state_t                state_q, state_d;
  logic                  rst_cnt_q, rst_cnt_d;
  logic [MAX_ITER_W-1:0] max_iter_q, max_iter_d;
  logic [MAX_ITER_W-1:0] iter_count_q, iter_count_d;
  logic [MAX_ITER_W-1:0] iter_inc_s;
  logic [2:0]            status_q, status_d;
  logic [NUM_COLS_W-1:0] pivot_col_q, pivot_col_d;
  logic [NUM_ROWS_W-1:0] pivot_row_q, pivot_row_d;
  logic [DATAW-1:0]      pivot_elem_q, pivot_elem_d;
  logic                  col_resetn_q, col_resetn_d;
  logic                  row_resetn_q, row_resetn_d;
  logic                  col_stream_start_q, col_stream_start_d;
  logic                  row_stream_start_q, row_stream_start_d;
  logic                  upd_start_q, upd_start_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wdog_expired_s;

`ifdef LP_SEQ_WATCHDOG_EN
  logic [31:0] wdog_q, wdog_d;

  // Count cycles spent in the current RUN/UPD state; restart on every state change.
  always_comb begin
    wdog_d         = 32'd0;
    wdog_expired_s = 1'b0;
    if ((state_q == S_COL_RUN) || (state_q == S_ROW_RUN) || (state_q == S_UPD)) begin
      wdog_expired_s = (wdog_q >= (WDOG_CYCLES - 32'd1));
      if (state_d != state_q) begin
        wdog_d = 32'd0;
      end else if (wdog_q != 32'hFFFF_FFFF) begin
        wdog_d = wdog_q + 32'd1;
      end else begin
        wdog_d = wdog_q;
      end
    end else begin
      wdog_d = 32'd0;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wdog_q <= 32'd0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  // No watchdog: the RUN/UPD states wait for their stage indefinitely.
  always_comb begin
    wdog_expired_s = 1'b0;
  end
`endif

  // Saturating increment of the completed-iteration count.
  always_comb begin
    if (iter_count_q == {MAX_ITER_W{1'b1}}) begin
      iter_inc_s = iter_count_q;
    end else begin
      iter_inc_s = iter_count_q + {{(MAX_ITER_W-1){1'b0}}, 1'b1};
    end
  end

  // Next-state logic, result latching and decode of the registered outputs.
  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = 1'b0;
    max_iter_d   = max_iter_q;
    iter_count_d = iter_count_q;
    status_d     = status_q;
    pivot_col_d  = pivot_col_q;
    pivot_row_d  = pivot_row_q;
    pivot_elem_d = pivot_elem_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_COL_RST;
          iter_count_d = {MAX_ITER_W{1'b0}};
          status_d     = STATUS_NONE;
          if (max_iter == {MAX_ITER_W{1'b0}}) begin
            max_iter_d = {{(MAX_ITER_W-1){1'b0}}, 1'b1};
          end else begin
            max_iter_d = max_iter;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_COL_RST: begin
        if (rst_cnt_q) begin
          state_d = S_COL_RUN;
        end else begin
          rst_cnt_d = 1'b1;
        end
      end
      S_COL_RUN: begin
        if (stg.col_terminate) begin
          state_d  = S_DONE;
          status_d = STATUS_OPTIMAL;
        end else if (stg.col_cont) begin
          state_d     = S_ROW_RST;
          pivot_col_d = stg.col_index_in;
        end else if (wdog_expired_s) begin
          state_d  = S_DONE;
          status_d = STATUS_TIMEOUT;
        end else begin
          state_d = S_COL_RUN;
        end
      end
      S_ROW_RST: begin
        if (rst_cnt_q) begin
          state_d = S_ROW_RUN;
        end else begin
          rst_cnt_d = 1'b1;
        end
      end
      S_ROW_RUN: begin
        if (stg.row_terminate) begin
          state_d  = S_DONE;
          status_d = STATUS_UNBOUNDED;
        end else if (stg.row_cont) begin
          state_d      = S_UPD;
          pivot_row_d  = stg.row_index_in;
          pivot_elem_d = stg.pivot_elem_in;
        end else if (wdog_expired_s) begin
          state_d  = S_DONE;
          status_d = STATUS_TIMEOUT;
        end else begin
          state_d = S_ROW_RUN;
        end
      end
      S_UPD: begin
        if (stg.upd_done) begin
          iter_count_d = iter_inc_s;
          if (iter_inc_s >= max_iter_q) begin
            state_d  = S_DONE;
            status_d = STATUS_ITER_LIM;
          end else begin
            state_d = S_COL_RST;
          end
        end else if (wdog_expired_s) begin
          state_d  = S_DONE;
          status_d = STATUS_TIMEOUT;
        end else begin
          state_d = S_UPD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the state being entered, so they are registered
    // and valid for the whole cycle spent in that state. Stage resets are held
    // high in DONE so the stage results stay observable.
    col_resetn_d       = !((state_d == S_IDLE) || (state_d == S_COL_RST));
    row_resetn_d       = !((state_d == S_IDLE) || (state_d == S_ROW_RST));
    col_stream_start_d = (state_d == S_COL_RUN) && (state_q != S_COL_RUN);
    row_stream_start_d = (state_d == S_ROW_RUN) && (state_q != S_ROW_RUN);
    upd_start_d        = (state_d == S_UPD) && (state_q != S_UPD);
    busy_d             = !((state_d == S_IDLE) || (state_d == S_DONE));
    done_d             = (state_d == S_DONE);
  end

  // State, latched results and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q            <= S_IDLE;
      rst_cnt_q          <= 1'b0;
      max_iter_q         <= {MAX_ITER_W{1'b0}};
      iter_count_q       <= {MAX_ITER_W{1'b0}};
      status_q           <= STATUS_NONE;
      pivot_col_q        <= {NUM_COLS_W{1'b0}};
      pivot_row_q        <= {NUM_ROWS_W{1'b0}};
      pivot_elem_q       <= {DATAW{1'b0}};
      col_resetn_q       <= 1'b0;
      row_resetn_q       <= 1'b0;
      col_stream_start_q <= 1'b0;
      row_stream_start_q <= 1'b0;
      upd_start_q        <= 1'b0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
    end else begin
      state_q            <= state_d;
      rst_cnt_q          <= rst_cnt_d;
      max_iter_q         <= max_iter_d;
      iter_count_q       <= iter_count_d;
      status_q           <= status_d;
      pivot_col_q        <= pivot_col_d;
      pivot_row_q        <= pivot_row_d;
      pivot_elem_q       <= pivot_elem_d;
      col_resetn_q       <= col_resetn_d;
      row_resetn_q       <= row_resetn_d;
      col_stream_start_q <= col_stream_start_d;
      row_stream_start_q <= row_stream_start_d;
      upd_start_q        <= upd_start_d;
      busy_q             <= busy_d;
      done_q             <= done_d;
    end
  end

  assign stg.col_resetn       = col_resetn_q;
  assign stg.row_resetn       = row_resetn_q;
  assign stg.col_stream_start = col_stream_start_q;
  assign stg.row_stream_start = row_stream_start_q;
  assign stg.upd_start        = upd_start_q;
  assign pivot_col            = pivot_col_q;
  assign pivot_row            = pivot_row_q;
  assign pivot_elem           = pivot_elem_q;
  assign iter_count           = iter_count_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign status               = status_q;

endmodule
